axi_arb2: RTL and testbench
===========================

# axi_arb2

Two-requester arbiter and transaction sequencer in front of the `axi` register/display slave. It accepts single read or write requests from two local masters (e.g. switch panel and scan engine) and grants one at a time. It drives the slave's valid/ready handshakes phase by phase and returns the slave's hex display byte to the granted master on reads. A per-transaction watchdog keeps a stalled slave from locking the bus.

## Interface
Parameters:
- `TO_CYCLES`, 16 — watchdog limit in cycles per handshake phase; legal range 2..255.

Ports:
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — synchronous, active-high.
- `req0`, `req1` in 1 — request; held high until the matching `done`.
- `we0`, `we1` in 1 — 1 = write, 0 = read; valid while `req` is high.
- `addr0`, `addr1` in 4 — target address.
- `wdata0`, `wdata1` in 4 — write data.
- `gnt0`, `gnt1` out 1 — one-cycle grant pulse.
- `done0`, `done1` out 1 — one-cycle completion pulse.
- `err` out 1 — valid with `done`; 1 = watchdog abort.
- `rd_hex` out 8 — captured `disp_hex_r`; valid with a read `done`, held until the next read completes.
- `ms_arvalid`, `ms_rready`, `ms_awvalid`, `ms_wvalid` out 1 — slave handshake drives.
- `SWM_arADDR` out 4 — shared read/write address to the slave.
- `SWM_wdata` out 4 — write data to the slave.
- `sm_arready`, `sm_rvalid`, `sm_awready`, `sm_wready` in 1 — slave handshake returns.
- `disp_hex_r` in 8 — slave read data (display byte).

## Operation
- States: IDLE, AR, R, AW, DONE.
- **IDLE**
  - If any `req` is high, select a winner.
  - Latch its `we`, `addr` and `wdata`.
  - Pulse its `gnt` and go to AR (read) or AW (write).
  - After `gnt`, the requester may change `addr`/`wdata`/`we`.
- **AR**: `ms_arvalid`=1 and `SWM_arADDR` = latched address. When `sm_arready` is sampled high, go to R.
- **R**: `ms_rready`=1. When `sm_rvalid` is sampled high, load `rd_hex` from `disp_hex_r` and go to DONE with `err`=0.
- **AW**
  - Drive `ms_awvalid`=1, `ms_wvalid`=1, `SWM_arADDR` = address, `SWM_wdata` = data.
  - Each valid drops independently on the edge after its own ready is sampled high.
  - When both have been accepted (same or different cycles), go to DONE with `err`=0.
- **DONE**
  - Pulse `done` for the owner.
  - Update the priority pointer.
  - Return to IDLE. No grant is issued in DONE, so back-to-back transactions have at least one IDLE cycle.
- **Watchdog**
  - An 8-bit counter is cleared on entry to AR, R and AW.
  - It increments every cycle spent in those states.
  - On reaching `TO_CYCLES-1` without the phase's ready: drop all valids/readies, go to DONE with `err`=1, and leave `rd_hex` unchanged.
- **Request rules**
  - A `req` dropped before its `gnt` is simply not served.
  - `req` of the non-owner is ignored until IDLE.
- Only one of `ms_arvalid`/`ms_awvalid` is ever high.

## Timing
- All outputs are registered.
- Reset values: `gnt*`, `done*`, `err`, all `ms_*` = 0; `SWM_arADDR`, `SWM_wdata`, `rd_hex` = 0; state IDLE; priority pointer points at master 1 (so master 0 wins first); watchdog = 0.
- `reset` asserted mid-transaction: every output is at its reset value on the next edge and no `done` is issued.
- Request at edge k (IDLE): `gnt` and the first valid are high after edge k+1.
- Read latency, slave ready immediately: `ms_arvalid` high k+1..k+2, `ms_rready` high k+2..k+3, `done` after k+3. Minimum req→done is 3 cycles.
- Write latency, both readies immediate: valids high one cycle, `done` after k+2.
- Abort: `done`/`err` are asserted exactly `TO_CYCLES` cycles after phase entry.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - Simultaneous requests go to the master not granted last.
  - The pointer updates in DONE, including aborts.
- Not defined:
  - Fixed priority; master 0 always wins simultaneous requests.
  - The pointer register is removed.

## Test plan
- Reset held 2 cycles, then `req0`=1 read addr 3, slave readies tied high, `disp_hex_r`=8'hB0 → `gnt0` at k+1, `ms_arvalid` one cycle with `SWM_arADDR`=3, `done0` at k+3, `rd_hex`=8'hB0, `err`=0.
- `req1` write addr 3, data 4; `sm_awready` high at once, `sm_wready` 2 cycles later → `ms_awvalid` 1 cycle, `ms_wvalid` 3 cycles, `done1` one cycle after `wready`.
- `req0` and `req1` both held high for two transactions → with `ARB_ROUND_ROBIN_EN`: grant order 0,1; without it: order 0,0.
- `sm_arready` tied low, `TO_CYCLES`=16 → `ms_arvalid` high 16 cycles, then `done0`=1, `err`=1, `rd_hex` unchanged, next `req` served normally.
- `reset` pulsed while in R → next edge: `ms_rready`=0, no `done`, state IDLE, master 0 wins the following simultaneous request.

Source files
------------

// File: rtl/axi_arb2.sv
// axi_arb2: two-requester arbiter and phase-by-phase transaction sequencer
// in front of the axi register/display slave, with a per-phase watchdog.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin instead of fixed
// priority between simultaneous requests).
module axi_arb2 #(
    parameter int TO_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [3:0] addr0,
    input  logic [3:0] addr1,
    input  logic [3:0] wdata0,
    input  logic [3:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       err,
    output logic [7:0] rd_hex,
    output logic       ms_arvalid,
    output logic       ms_rready,
    output logic       ms_awvalid,
    output logic       ms_wvalid,
    output logic [3:0] SWM_arADDR,
    output logic [3:0] SWM_wdata,
    input  logic       sm_arready,
    input  logic       sm_rvalid,
    input  logic       sm_awready,
    input  logic       sm_wready,
    input  logic [7:0] disp_hex_r
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Watchdog fires when the counter has already reached this value
    localparam logic [7:0] WD_LIMIT = 8'(TO_CYCLES - 1);

    state_t     state_r;
    logic       owner_r;
    logic [7:0] wd_r;
`ifdef ARB_ROUND_ROBIN_EN
    logic       ptr_r;      // last master served; the other one wins a tie
`endif

    logic       pick1_s;
    logic       sel_we_s;
    logic [3:0] sel_addr_s;
    logic [3:0] sel_wdata_s;
    logic       wd_hit_s;
    logic       aw_ok_s;
    logic       w_ok_s;

    // Winner selection and request-side operand mux for the IDLE grant
    always_comb begin
        pick1_s = 1'b0;
        if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
            pick1_s = ~ptr_r;
`else
            pick1_s = 1'b0;
`endif
        end else if (req1) begin
            pick1_s = 1'b1;
        end else begin
            pick1_s = 1'b0;
        end
        sel_we_s    = pick1_s ? we1    : we0;
        sel_addr_s  = pick1_s ? addr1  : addr0;
        sel_wdata_s = pick1_s ? wdata1 : wdata0;
    end

    // A write channel counts as accepted once its valid has dropped or its ready is seen
    assign aw_ok_s  = ~ms_awvalid | sm_awready;
    assign w_ok_s   = ~ms_wvalid  | sm_wready;
    assign wd_hit_s = (wd_r == WD_LIMIT);

    // Sequencer FSM with registered grant/done/handshake outputs and watchdog
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            owner_r    <= 1'b0;
            wd_r       <= 8'd0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err        <= 1'b0;
            rd_hex     <= 8'd0;
            ms_arvalid <= 1'b0;
            ms_rready  <= 1'b0;
            ms_awvalid <= 1'b0;
            ms_wvalid  <= 1'b0;
            SWM_arADDR <= 4'd0;
            SWM_wdata  <= 4'd0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_r      <= 1'b1;
`endif
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    err <= 1'b0;
                    if (req0 || req1) begin
                        owner_r    <= pick1_s;
                        gnt0       <= ~pick1_s;
                        gnt1       <= pick1_s;
                        SWM_arADDR <= sel_addr_s;
                        SWM_wdata  <= sel_wdata_s;
                        wd_r       <= 8'd0;
                        if (sel_we_s) begin
                            ms_awvalid <= 1'b1;
                            ms_wvalid  <= 1'b1;
                            state_r    <= S_AW;
                        end else begin
                            ms_arvalid <= 1'b1;
                            state_r    <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (sm_arready) begin
                        ms_arvalid <= 1'b0;
                        ms_rready  <= 1'b1;
                        wd_r       <= 8'd0;
                        state_r    <= S_R;
                    end else if (wd_hit_s) begin
                        ms_arvalid <= 1'b0;
                        done0      <= ~owner_r;
                        done1      <= owner_r;
                        err        <= 1'b1;
                        state_r    <= S_DONE;
                    end else begin
                        wd_r <= wd_r + 8'd1;
                    end
                end
                S_R: begin
                    if (sm_rvalid) begin
                        ms_rready <= 1'b0;
                        rd_hex    <= disp_hex_r;
                        done0     <= ~owner_r;
                        done1     <= owner_r;
                        err       <= 1'b0;
                        state_r   <= S_DONE;
                    end else if (wd_hit_s) begin
                        ms_rready <= 1'b0;
                        done0     <= ~owner_r;
                        done1     <= owner_r;
                        err       <= 1'b1;
                        state_r   <= S_DONE;
                    end else begin
                        wd_r <= wd_r + 8'd1;
                    end
                end
                S_AW: begin
                    if (aw_ok_s && w_ok_s) begin
                        ms_awvalid <= 1'b0;
                        ms_wvalid  <= 1'b0;
                        done0      <= ~owner_r;
                        done1      <= owner_r;
                        err        <= 1'b0;
                        state_r    <= S_DONE;
                    end else if (wd_hit_s) begin
                        ms_awvalid <= 1'b0;
                        ms_wvalid  <= 1'b0;
                        done0      <= ~owner_r;
                        done1      <= owner_r;
                        err        <= 1'b1;
                        state_r    <= S_DONE;
                    end else begin
                        ms_awvalid <= ms_awvalid & ~sm_awready;
                        ms_wvalid  <= ms_wvalid & ~sm_wready;
                        wd_r       <= wd_r + 8'd1;
                    end
                end
                S_DONE: begin
                    err <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_r <= owner_r;
`endif
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_arb2.sv
// tb_axi_arb2: directed, scoreboard-based bench for axi_arb2.
module tb_axi_arb2;

    logic       clk;
    logic       reset;
    logic       req0, req1, we0, we1;
    logic [3:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, done0, done1, err;
    logic [7:0] rd_hex;
    logic       ms_arvalid, ms_rready, ms_awvalid, ms_wvalid;
    logic [3:0] SWM_arADDR, SWM_wdata;
    logic       sm_arready, sm_rvalid, sm_awready, sm_wready;
    logic [7:0] disp_hex_r;

    typedef struct {
        bit         mst;
        bit         err;
        logic [7:0] hex;
    } exp_t;

    exp_t sb[$];
    bit   gnt_log[$];
    int   checks = 0;
    int   passed = 0;
    int   failed = 0;

    axi_arb2 #(.TO_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err(err), .rd_hex(rd_hex),
        .ms_arvalid(ms_arvalid), .ms_rready(ms_rready),
        .ms_awvalid(ms_awvalid), .ms_wvalid(ms_wvalid),
        .SWM_arADDR(SWM_arADDR), .SWM_wdata(SWM_wdata),
        .sm_arready(sm_arready), .sm_rvalid(sm_rvalid),
        .sm_awready(sm_awready), .sm_wready(sm_wready),
        .disp_hex_r(disp_hex_r)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done0 || done1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Output monitor: grant log, valid exclusivity and scoreboard on every done
    always @(posedge clk) begin
        #1;
        if (gnt0) gnt_log.push_back(1'b0);
        if (gnt1) gnt_log.push_back(1'b1);
        if (ms_arvalid || ms_awvalid)
            chk("one_valid", {31'd0, ms_arvalid & ms_awvalid}, 32'd0);
        if (done0 || done1) begin
            chk("sb_pending", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_owner", {30'd0, done1, done0}, e.mst ? 32'd2 : 32'd1);
                chk("sb_err", {31'd0, err}, {31'd0, e.err});
                chk("sb_rd_hex", {24'd0, rd_hex}, {24'd0, e.hex});
            end
        end
    end

    initial begin
        bit   ok;
        int   cnt;
        exp_t e;

        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 4'd0; addr1 = 4'd0; wdata0 = 4'd0; wdata1 = 4'd0;
        sm_arready = 1'b1; sm_rvalid = 1'b1; sm_awready = 1'b1; sm_wready = 1'b1;
        disp_hex_r = 8'hB0;
        tick();
        tick();
        chk("rst_pulses", {28'd0, gnt0, gnt1, done0, done1}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ms", {28'd0, ms_arvalid, ms_rready, ms_awvalid, ms_wvalid}, 32'd0);
        chk("rst_data", {16'd0, rd_hex, SWM_arADDR, SWM_wdata}, 32'd0);
        reset = 1'b0;

        // Read by master 0, slave ready immediately
        e.mst = 1'b0; e.err = 1'b0; e.hex = 8'hB0; sb.push_back(e);
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
        tick();
        chk("rd_gnt0", {30'd0, gnt0, gnt1}, 32'd2);
        chk("rd_arvalid", {31'd0, ms_arvalid}, 32'd1);
        chk("rd_addr", {28'd0, SWM_arADDR}, 32'd3);
        addr0 = 4'hF;
        tick();
        chk("rd_phase_r", {30'd0, ms_arvalid, ms_rready}, 32'd1);
        chk("rd_gnt_pulse", {31'd0, gnt0}, 32'd0);
        chk("rd_addr_held", {28'd0, SWM_arADDR}, 32'd3);
        tick();
        chk("rd_done0", {31'd0, done0}, 32'd1);
        chk("rd_rready_off", {31'd0, ms_rready}, 32'd0);
        req0 = 1'b0;
        tick();
        chk("rd_done_pulse", {31'd0, done0}, 32'd0);

        // Write by master 1, wready two cycles after awready
        e.mst = 1'b1; e.err = 1'b0; e.hex = 8'hB0; sb.push_back(e);
        sm_wready = 1'b0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'd3; wdata1 = 4'd4;
        tick();
        chk("wr_gnt1", {30'd0, gnt0, gnt1}, 32'd1);
        chk("wr_valids", {30'd0, ms_awvalid, ms_wvalid}, 32'd3);
        chk("wr_addr_data", {24'd0, SWM_arADDR, SWM_wdata}, 32'h34);
        tick();
        chk("wr_aw_dropped", {30'd0, ms_awvalid, ms_wvalid}, 32'd1);
        tick();
        chk("wr_w_still", {30'd0, ms_awvalid, ms_wvalid}, 32'd1);
        chk("wr_no_early_done", {31'd0, done1}, 32'd0);
        sm_wready = 1'b1;
        tick();
        chk("wr_done1", {31'd0, done1}, 32'd1);
        chk("wr_w_dropped", {31'd0, ms_wvalid}, 32'd0);
        req1 = 1'b0;
        tick();

        // Simultaneous requests held for two transactions
        disp_hex_r = 8'h5A;
        gnt_log.delete();
        e.mst = 1'b0; e.err = 1'b0; e.hex = 8'h5A; sb.push_back(e);
`ifdef ARB_ROUND_ROBIN_EN
        e.mst = 1'b1;
`else
        e.mst = 1'b0;
`endif
        sb.push_back(e);
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd2;
        wait_done(20, ok);
        chk("arb_first_done", {31'd0, ok}, 32'd1);
        wait_done(20, ok);
        chk("arb_second_done", {31'd0, ok}, 32'd1);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        chk("arb_grant_count", gnt_log.size(), 32'd2);
        if (gnt_log.size() == 2) begin
            chk("arb_grant_0", {31'd0, gnt_log[0]}, 32'd0);
            chk("arb_grant_1", {31'd0, gnt_log[1]}, {31'd0, e.mst});
        end

        // Watchdog abort on a stuck arready
        sm_arready = 1'b0;
        disp_hex_r = 8'hC3;
        e.mst = 1'b0; e.err = 1'b1; e.hex = 8'h5A; sb.push_back(e);
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd2;
        tick();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!ms_arvalid) break;
            cnt++;
            tick();
        end
        chk("to_arvalid_cycles", cnt, 32'd16);
        chk("to_done0_err", {30'd0, done0, err}, 32'd3);
        chk("to_rd_hex_kept", {24'd0, rd_hex}, 32'h5A);
        req0 = 1'b0;
        sm_arready = 1'b1;
        tick();

        // Normal read after the abort
        disp_hex_r = 8'h3C;
        e.mst = 1'b1; e.err = 1'b0; e.hex = 8'h3C; sb.push_back(e);
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd5;
        wait_done(20, ok);
        chk("post_to_done", {31'd0, ok}, 32'd1);
        req1 = 1'b0;
        tick();

        // Reset pulsed while waiting in R
        sm_rvalid = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd7;
        tick();
        tick();
        chk("rst_mid_rready", {31'd0, ms_rready}, 32'd1);
        reset = 1'b1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd6;
        tick();
        chk("rst_mid_ms", {28'd0, ms_arvalid, ms_rready, ms_awvalid, ms_wvalid}, 32'd0);
        chk("rst_mid_done", {30'd0, done0, done1}, 32'd0);
        chk("rst_mid_data", {16'd0, rd_hex, SWM_arADDR, SWM_wdata}, 32'd0);
        reset = 1'b0;
        sm_rvalid = 1'b1;
        disp_hex_r = 8'h99;
        e.mst = 1'b0; e.err = 1'b0; e.hex = 8'h99; sb.push_back(e);
        tick();
        chk("rst_after_gnt", {30'd0, gnt0, gnt1}, 32'd2);
        wait_done(20, ok);
        chk("rst_after_done", {31'd0, ok}, 32'd1);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();
        tick();
        chk("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
